// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
// master: the loader. It accepts the byte stream and drives the memory
//         write port and status.
// slave : the host/boot side. It supplies bytes and start/word_count,
//         and observes the write port.
interface imem_loader_if #(
  parameter int unsigned depth       = 32,
  parameter int unsigned word_length = 32
);
  localparam int unsigned aw = $clog2(depth);

  logic                   start;
  logic [aw:0]            word_count;
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   mem_we;
  logic [aw-1:0]          mem_addr;
  logic [word_length-1:0] mem_wdata;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader. It packs a little-endian byte stream into
// instruction words and writes each word to consecutive addresses from 0.
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   bus (master)      - start/word_count command; byte_in/byte_valid/byte_ready
//                       stream; mem_we/mem_addr/mem_wdata write port;
//                       busy/done status
module imem_loader #(
  parameter int unsigned depth       = 32,
  parameter int unsigned word_length = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.master bus
);

  localparam int unsigned aw  = $clog2(depth);
  localparam int unsigned cw  = aw + 1;
  localparam int unsigned bpw = word_length / 8;
  localparam int unsigned iw  = (bpw > 1) ? $clog2(bpw) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t        state;
  logic [iw-1:0] idx;
  logic [cw-1:0] cnt;
  logic [cw-1:0] nwritten;

  logic [cw-1:0] cnt_clamped_c;
  logic          accept_c;

  // A requested count larger than the memory is clamped to the memory size.
  always_comb begin
    cnt_clamped_c = bus.word_count;
    if (bus.word_count > cw'(depth)) cnt_clamped_c = cw'(depth);
  end

  assign accept_c = (state == LOAD) && bus.byte_valid && bus.byte_ready;

  // Load sequencer. All outputs are registered and track state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      nwritten       <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            cnt          <= cnt_clamped_c;
            bus.mem_addr <= '0;
            idx          <= '0;
            nwritten     <= '0;
            if (cnt_clamped_c == '0) begin
              state          <= DONE;
              bus.done       <= 1'b1;
              bus.busy       <= 1'b0;
              bus.byte_ready <= 1'b0;
            end else begin
              state          <= LOAD;
              bus.done       <= 1'b0;
              bus.busy       <= 1'b1;
              bus.byte_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept_c) begin
            // Little-endian: byte k of the word lands in bits [8k+7:8k].
            for (int unsigned k = 0; k < bpw; k++) begin
              if (idx == iw'(k)) bus.mem_wdata[8*k +: 8] <= bus.byte_in;
            end
            if (idx == iw'(bpw - 1)) begin
              state          <= WRITE;
              bus.byte_ready <= 1'b0;
              bus.mem_we     <= 1'b1;
            end else begin
              idx <= idx + iw'(1);
            end
          end
        end

        WRITE: begin
          bus.mem_we   <= 1'b0;
          // Wraps to 0 after the last location when cnt == depth.
          bus.mem_addr <= bus.mem_addr + aw'(1);
          idx          <= '0;
          nwritten     <= nwritten + cw'(1);
          if (nwritten + cw'(1) == cnt) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            state          <= LOAD;
            bus.byte_ready <= 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          bus.byte_ready <= 1'b0;
          bus.mem_we     <= 1'b0;
          bus.busy       <= 1'b0;
          bus.done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
